mod_n_updown_counter: RTL and testbench

//  Parametrised, cascadable modulo-N up/down counter. It is the general successor of the

---
 rtl/mod_n_updown_counter.sv | 117 +++++++++++
 tb/tb_mod_n_updown_counter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with a runtime-programmable modulus, synchronous
// clear and load, and a combinational terminal count for cascading stages.
// All count arithmetic is carried one bit wider than q, so N = 2**WIDTH works
// and the counter wraps at all ones without overflow.
module mod_n_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             set_mod,
  input  logic [WIDTH:0]   mod_n,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic [WIDTH:0]   modulus,
  output logic             err
);

  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] MIN_MOD = (WIDTH+1)'(2);
  localparam logic [WIDTH:0] MAX_MOD = ONE << WIDTH;
  localparam logic [WIDTH:0] RST_MOD = (WIDTH+1)'(MODULUS);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   top;
  logic             at_top;
  logic             at_zero;

  logic [WIDTH:0]   q_op;
  logic             load_bad;
  logic             count_wrap;

  logic             mod_req;
  logic             mod_ok;
  logic             mod_take;
  logic             mod_bad;
  logic             force_zero;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   mod_nxt;
  logic             co_nxt;
  logic             err_nxt;

  assign q_ext   = {1'b0, q};
  assign top     = modulus - ONE;
  assign at_top  = (q_ext == top);
  assign at_zero = (q_ext == '0);

  // Terminal count is purely combinational so a chained upper stage advances
  // on the very same edge as the lower stage wraps.
  assign tc = en & (up ? at_top : at_zero);

  // Count operation against the currently active modulus: clear beats load,
  // load beats counting, otherwise hold. A wrap only counts as a carry when
  // it came from an actual count step.
  always_comb begin
    q_op       = q_ext;
    load_bad   = 1'b0;
    count_wrap = 1'b0;
    if (clr) begin
      q_op = '0;
    end else if (load) begin
      if ({1'b0, d} < modulus) begin
        q_op = {1'b0, d};
      end else begin
        q_op     = '0;
        load_bad = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        q_op = at_top ? '0 : (q_ext + ONE);
      end else begin
        q_op = at_zero ? top : (q_ext - ONE);
      end
      count_wrap = tc;
    end
  end

  // Modulus update. Disabling the stage freezes the modulus too, so a
  // request only takes part while en is high. If the freshly computed count
  // does not fit the new modulus it is pulled back to zero, and that edge is
  // not reported as a carry.
  always_comb begin
    mod_req    = set_mod & en;
    mod_ok     = (mod_n >= MIN_MOD) && (mod_n <= MAX_MOD);
    mod_take   = mod_req & mod_ok;
    mod_bad    = mod_req & ~mod_ok;
    force_zero = mod_take && (q_op >= mod_n);
    q_nxt      = force_zero ? '0 : q_op[WIDTH-1:0];
    mod_nxt    = mod_take ? mod_n : modulus;
    co_nxt     = count_wrap & ~force_zero;
    err_nxt    = load_bad | mod_bad;
  end

  // State register; reset drops any pending operation and restores the
  // build-time modulus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      modulus <= RST_MOD;
      co      <= 1'b0;
      err     <= 1'b0;
    end else begin
      q       <= q_nxt;
      modulus <= mod_nxt;
      co      <= co_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Self-checking bench for mod_n_updown_counter: a single N=12 stage driven
// through counting, loading and modulus changes, plus a 10/6 cascade.
module tb_mod_n_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up, clr, load, set_mod;
  logic [3:0] d;
  logic [4:0] mod_n;
  logic [3:0] q;
  logic       tc, co, err;
  logic [4:0] modulus;

  logic       en_lo;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_co, hi_co, lo_err, hi_err;
  logic [4:0] lo_mod, hi_mod;

  int total = 0;
  int bad   = 0;

  // Reference state of the single stage
  int mq, mmod;

  typedef struct {
    int q;
    int co;
    int err;
    int m;
  } exp_t;

  exp_t sbq[$];
  int   cq[$];

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(12)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .d(d), .set_mod(set_mod), .mod_n(mod_n), .q(q), .tc(tc), .co(co),
    .modulus(modulus), .err(err)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10)) lo (
    .clk(clk), .reset(reset), .en(en_lo), .up(1'b1), .clr(1'b0), .load(1'b0),
    .d(4'd0), .set_mod(1'b0), .mod_n(5'd0), .q(lo_q), .tc(lo_tc), .co(lo_co),
    .modulus(lo_mod), .err(lo_err)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(6)) hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up(1'b1), .clr(1'b0), .load(1'b0),
    .d(4'd0), .set_mod(1'b0), .mod_n(5'd0), .q(hi_q), .tc(hi_tc), .co(hi_co),
    .modulus(hi_mod), .err(hi_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case the run ever loses its way
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One clock of the single stage: check tc before the edge, push the
  // expected post-edge state, then pop and compare after the edge.
  task automatic cycle(input string tag);
    exp_t e, g;
    int   qn, con, er, mn;
    logic tce;
    #1;
    tce = en && (up ? (mq == mmod - 1) : (mq == 0));
    total++;
    if (tc !== tce) begin
      bad++;
      $display("[TB] FAIL %s tc: got %b want %b", tag, tc, tce);
    end
    qn = mq; con = 0; er = 0; mn = mmod;
    if (clr) qn = 0;
    else if (load) begin
      if (int'(d) < mmod) qn = int'(d);
      else begin qn = 0; er = 1; end
    end else if (en) begin
      if (up) qn = (mq == mmod - 1) ? 0 : mq + 1;
      else    qn = (mq == 0) ? mmod - 1 : mq - 1;
      con = tce ? 1 : 0;
    end
    if (en && set_mod) begin
      if (int'(mod_n) >= 2 && int'(mod_n) <= 16) begin
        mn = int'(mod_n);
        if (qn >= mn) begin qn = 0; con = 0; end
      end else er = 1;
    end
    e.q = qn; e.co = con; e.err = er; e.m = mn;
    sbq.push_back(e);
    mq = qn; mmod = mn;
    @(posedge clk); #1;
    g = sbq.pop_front();
    total++;
    if (q !== 4'(g.q)) begin
      bad++; $display("[TB] FAIL %s q: got %0d want %0d", tag, q, g.q);
    end
    total++;
    if (co !== 1'(g.co)) begin
      bad++; $display("[TB] FAIL %s co: got %b want %0d", tag, co, g.co);
    end
    total++;
    if (err !== 1'(g.err)) begin
      bad++; $display("[TB] FAIL %s err: got %b want %0d", tag, err, g.err);
    end
    total++;
    if (modulus !== 5'(g.m)) begin
      bad++; $display("[TB] FAIL %s modulus: got %0d want %0d", tag, modulus, g.m);
    end
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; set_mod = 1'b0;
    d = 4'd0; mod_n = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en_lo = 1'b0;
    idle_inputs();
    #12;
    total++;
    if (q !== 4'd0 || co !== 1'b0 || err !== 1'b0 || modulus !== 5'd12 || tc !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: got q=%0d co=%b err=%b mod=%0d tc=%b want 0 0 0 12 0",
               q, co, err, modulus, tc);
    end
    @(negedge clk);
    reset = 1'b0;
    mq = 0; mmod = 12;
  endtask

  task automatic test_count_up();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 14; i++) cycle($sformatf("up%0d", i));
    total++;
    if (q !== 4'd2) begin
      bad++; $display("[TB] FAIL up_end q: got %0d want 2", q);
    end
  endtask

  task automatic test_count_down();
    clr = 1'b1;
    cycle("down_clr");
    clr = 1'b0; up = 1'b0;
    cycle("down_wrap");
    total++;
    if (q !== 4'd11 || co !== 1'b1) begin
      bad++; $display("[TB] FAIL down_wrap: got q=%0d co=%b want 11 1", q, co);
    end
    cycle("down10");
    cycle("down9");
    total++;
    if (q !== 4'd9 || co !== 1'b0) begin
      bad++; $display("[TB] FAIL down_end: got q=%0d co=%b want 9 0", q, co);
    end
  endtask

  task automatic test_load_clr();
    en = 1'b0;
    load = 1'b1; d = 4'd7;
    cycle("load7");
    total++;
    if (q !== 4'd7) begin
      bad++; $display("[TB] FAIL load7 q: got %0d want 7", q);
    end
    d = 4'd13;
    cycle("load13");
    total++;
    if (q !== 4'd0 || err !== 1'b1) begin
      bad++; $display("[TB] FAIL load13: got q=%0d err=%b want 0 1", q, err);
    end
    load = 1'b0;
    cycle("load_idle");
    load = 1'b1; d = 4'd11;
    cycle("load11");
    clr = 1'b1; d = 4'd5;
    cycle("clr_load");
    total++;
    if (q !== 4'd0 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL clr_load: got q=%0d err=%b want 0 0", q, err);
    end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_set_mod();
    load = 1'b1; d = 4'd9;
    cycle("pre_load9");
    load = 1'b0; en = 1'b1; up = 1'b1;
    set_mod = 1'b1; mod_n = 5'd6;
    cycle("setmod6");
    total++;
    if (q !== 4'd0 || modulus !== 5'd6 || co !== 1'b0) begin
      bad++; $display("[TB] FAIL setmod6: got q=%0d mod=%0d co=%b want 0 6 0", q, modulus, co);
    end
    mod_n = 5'd1;
    cycle("setmod1");
    mod_n = 5'd17;
    cycle("setmod17");
    total++;
    if (modulus !== 5'd6 || err !== 1'b1) begin
      bad++; $display("[TB] FAIL setmod17: got mod=%0d err=%b want 6 1", modulus, err);
    end
    mod_n = 5'd16; up = 1'b0;
    cycle("setmod16");
    set_mod = 1'b0;
    cycle("dn16_a");
    cycle("dn16_wrap");
    total++;
    if (q !== 4'd15 || co !== 1'b1) begin
      bad++; $display("[TB] FAIL wrap16: got q=%0d co=%b want 15 1", q, co);
    end
    up = 1'b1;
    cycle("up16_wrap");
  endtask

  task automatic test_reset_midcount();
    en = 1'b1; up = 1'b1;
    cycle("mid_a");
    cycle("mid_b");
    #2 reset = 1'b1;
    #1;
    total++;
    if (q !== 4'd0 || modulus !== 5'd12 || co !== 1'b0 || err !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset: got q=%0d mod=%0d co=%b err=%b want 0 12 0 0",
                      q, modulus, co, err);
    end
    @(posedge clk); #1;
    total++;
    if (q !== 4'd0) begin
      bad++; $display("[TB] FAIL reset_hold q: got %0d want 0", q);
    end
    @(negedge clk);
    reset = 1'b0;
    mq = 0; mmod = 12;
    sbq.delete();
    cycle("resume");
    total++;
    if (q !== 4'd1) begin
      bad++; $display("[TB] FAIL resume q: got %0d want 1", q);
    end
    en = 1'b0;
  endtask

  task automatic test_cascade();
    int exp_v, lo_e, hi_e;
    idle_inputs();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(negedge clk);
    en_lo = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cq.push_back(k);
      if (k == 60) begin
        total++;
        if (hi_tc !== 1'b1) begin
          bad++; $display("[TB] FAIL cascade_hi_tc: got %b want 1", hi_tc);
        end
      end
      @(posedge clk); #1;
      exp_v = cq.pop_front();
      lo_e = exp_v % 10;
      hi_e = (exp_v / 10) % 6;
      total++;
      if (lo_q !== 4'(lo_e) || hi_q !== 4'(hi_e)) begin
        bad++; $display("[TB] FAIL cascade_%0d: got (%0d,%0d) want (%0d,%0d)",
                        k, lo_q, hi_q, lo_e, hi_e);
      end
      if (k == 59) begin
        total++;
        if (lo_q !== 4'd9 || hi_q !== 4'd5 || hi_co !== 1'b0) begin
          bad++; $display("[TB] FAIL cascade59: got (%0d,%0d) co=%b want (9,5) 0", lo_q, hi_q, hi_co);
        end
      end
      if (k == 60) begin
        total++;
        if (hi_co !== 1'b1 || lo_co !== 1'b1) begin
          bad++; $display("[TB] FAIL cascade60_co: got hi=%b lo=%b want 1 1", hi_co, lo_co);
        end
      end
    end
    en_lo = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clr();
    test_set_mod();
    test_reset_midcount();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
